rv32i_memory: RTL and testbench

Memory responder at the far end of the `rv32i_top` instruction and data ports. It contains:

- a Harvard instruction memory with a combinational read port, addressed by the core's 8-bit `pc`;
- a data memory with a combinational read port and a synchronous word write port.

A streaming loader FSM fills instruction memory through a valid/ready handshake. While it loads, the block holds the core in reset through `core_rst`, and releases it when the load completes.

---
 rtl/rv32i_mem_pkg.sv | 17 +
 rtl/mem_loader.sv | 86 ++++++++
 rtl/rv32i_memory.sv | 97 +++++++++
 tb/tb_rv32i_memory.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the rv32i memory responder.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } mem_state_t;

    localparam int IMEM_WORDS_DEF = 64;
    localparam int DMEM_WORDS_DEF = 256;

    function automatic logic [29:0] addr_to_index(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Streaming instruction-memory loader; holds the core in reset until the image is in place.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for load_start
// LOAD  | accepting words into imem, core held in reset
// RUN   | image loaded, core released, data port live
module mem_loader
    import rv32i_mem_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int IMEM_AW    = $clog2(IMEM_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start_i,
    input  logic [7:0]         load_count_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    output logic               load_done_o,
    output logic               core_rst_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_idx_o
);

    localparam logic [7:0] CNT_MAX = 8'(IMEM_WORDS);

    mem_state_t state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] counter_q, counter_d;
    logic [7:0] count_clamped;

    assign count_clamped = (load_count_i > CNT_MAX) ? CNT_MAX : load_count_i;
    assign imem_idx_o    = counter_q[IMEM_AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        counter_d    = counter_q;
        core_rst_o   = 1'b1;
        load_ready_o = 1'b0;
        load_done_o  = 1'b0;
        imem_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    count_d   = count_clamped;
                    counter_d = '0;
                    state_d   = (count_clamped == 8'd0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    imem_we_o = 1'b1;
                    counter_d = counter_q + 8'd1;
                    if (counter_q == count_q - 8'd1) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                core_rst_o  = 1'b0;
                load_done_o = 1'b1;
                if (load_start_i) begin
                    count_d   = count_clamped;
                    counter_d = '0;
                    state_d   = (count_clamped == 8'd0) ? RUN : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/rv32i_memory.sv
// Instruction and data memories behind the rv32i core, plus the loader and fault flag.
module rv32i_memory
    import rv32i_mem_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc,
    output logic [31:0] instruction,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_data,
    output logic        core_rst,
    input  logic        load_start,
    input  logic [7:0]  load_count,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_done,
    output logic        fault
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    logic [31:0]        imem_q [IMEM_WORDS];
    logic [31:0]        dmem_q [DMEM_WORDS];
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_idx;
    logic [29:0]        word_idx;
    logic [DMEM_AW-1:0] dmem_idx;
    logic               in_range;
    logic               run;
    logic               dmem_we;
    logic [31:0]        rd_word;
    logic               fault_q, fault_d;
    logic [1:0]         unused_pc_lsb;

    mem_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .IMEM_AW    (IMEM_AW)
    ) u_loader (
        .clk          (clk),
        .rst          (rst),
        .load_start_i (load_start),
        .load_count_i (load_count),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_done_o  (load_done),
        .core_rst_o   (core_rst),
        .imem_we_o    (imem_we),
        .imem_idx_o   (imem_idx)
    );

    assign run           = load_done;
    assign unused_pc_lsb = pc[1:0];
    assign instruction   = imem_q[pc[IMEM_AW+1:2]];

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_idx] <= load_data;
        end
    end

    assign word_idx = addr_to_index(mem_addr);
    assign in_range = word_idx < 30'(DMEM_WORDS);
    assign dmem_idx = word_idx[DMEM_AW-1:0];
    assign dmem_we  = run && mem_write_enable && in_range;

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem_q[dmem_idx] <= mem_write_data;
        end
    end

    // Right-align the addressed byte/halfword so the core extracts from the low bits.
    assign rd_word  = (run && in_range) ? dmem_q[dmem_idx] : 32'd0;
    assign mem_data = rd_word >> {mem_addr[1:0], 3'b000};

    // No read strobe exists, so only stores can be judged as real faulting accesses.
    assign fault_d = fault_q
                   | (run && mem_write_enable && (!in_range || (mem_addr[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_rv32i_memory.sv
// Self-checking bench for rv32i_memory: loader handshake, data port, faults and reset recovery.
module tb_rv32i_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data;
    logic        core_rst;
    logic        load_start;
    logic [7:0]  load_count;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_w;

    rv32i_memory dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .instruction      (instruction),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_data         (mem_data),
        .core_rst         (core_rst),
        .load_start       (load_start),
        .load_count       (load_count),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_ready       (load_ready),
        .load_done        (load_done),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [31:0] v);
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: actual size 0 required >0");
            v = 32'hxxxxxxxx;
        end else begin
            v = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: actual %b required 1", core_rst); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_load_ready: actual %b required 0", load_ready); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: actual %b required 0", load_done); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: actual %b required 0", fault); end
    endtask

    task automatic test_zero_load();
        load_start = 1'b1;
        load_count = 8'd0;
        cyc();
        load_start = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL zero_load_done: actual %b required 1", load_done); end
        n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL zero_load_core_rst: actual %b required 0", core_rst); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL zero_load_ready: actual %b required 0", load_ready); end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        words[2] = 32'h00208113;
        load_start = 1'b1;
        load_count = 8'd3;
        cyc();
        load_start = 1'b0;
        #1;
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL load_core_rst_high: actual %b required 1", core_rst); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_high: actual %b required 1", load_ready); end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                load_valid = 1'b0;
                cyc();
                cyc();
                n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_gap_done: actual %b required 0", load_done); end
            end
            load_valid = 1'b1;
            load_data  = words[i];
            sb.push_back(words[i]);
            #1;
            n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL load_word%0d_core_rst: actual %b required 1", i, core_rst); end
            cyc();
        end
        load_valid = 1'b0;
        #1;
        n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL load_end_core_rst: actual %b required 0", core_rst); end
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL load_end_done: actual %b required 1", load_done); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_end_ready: actual %b required 0", load_ready); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i * 4);
            #1;
            pop_exp(exp_w);
            n_checks++; if (instruction !== exp_w) begin n_fail++; $display("FAIL imem_pc%0d: actual %h required %h", i * 4, instruction, exp_w); end
        end
        pc = 8'd0;
    endtask

    task automatic test_dmem_rw();
        logic [7:0] offs [3];
        logic [31:0] vals [3];
        offs[0] = 8'h10; vals[0] = 32'hDEADBEEF;
        offs[1] = 8'h11; vals[1] = 32'h00DEADBE;
        offs[2] = 8'h13; vals[2] = 32'h000000DE;
        mem_write_enable = 1'b1;
        mem_addr = 32'h0;  mem_write_data = 32'h0000A5A5;
        cyc();
        mem_addr = 32'h10; mem_write_data = 32'h11111111;
        cyc();
        mem_write_data = 32'hDEADBEEF;
        sb.push_back(32'h11111111);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL dmem_same_cycle_old: actual %h required %h", mem_data, exp_w); end
        cyc();
        mem_write_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_addr = {24'd0, offs[i]};
            sb.push_back(vals[i]);
            #1;
            pop_exp(exp_w);
            n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL dmem_read_%h: actual %h required %h", offs[i], mem_data, exp_w); end
        end
        mem_addr = 32'h0;
        sb.push_back(32'h0000A5A5);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL dmem_read_0: actual %h required %h", mem_data, exp_w); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL dmem_no_fault: actual %b required 0", fault); end
    endtask

    task automatic test_out_of_range();
        mem_addr = 32'h400;
        mem_write_enable = 1'b1;
        mem_write_data = 32'hCAFEF00D;
        #1;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL oor_fault_early: actual %b required 0", fault); end
        cyc();
        mem_write_enable = 1'b0;
        #1;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL oor_fault_set: actual %b required 1", fault); end
        n_checks++; if (mem_data !== 32'd0) begin n_fail++; $display("FAIL oor_read_zero: actual %h required 00000000", mem_data); end
        mem_addr = 32'h0;
        sb.push_back(32'h0000A5A5);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL oor_no_wrap: actual %h required %h", mem_data, exp_w); end
        cyc(); cyc(); cyc();
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL oor_fault_sticky: actual %b required 1", fault); end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        load_count = 8'd5;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hAAAA0000 + 32'(i);
            cyc();
        end
        load_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_core_rst: actual %b required 1", core_rst); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: actual %b required 0", load_ready); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: actual %b required 0", load_done); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL midrst_fault_clear: actual %b required 0", fault); end
        // Stores while not in RUN must be ignored.
        mem_write_enable = 1'b1;
        mem_addr = 32'h10;
        mem_write_data = 32'h0BADBEEF;
        load_start = 1'b1;
        load_count = 8'd5;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                load_valid = 1'b0;
                load_start = 1'b1;
                load_count = 8'd2;
                cyc();
                load_start = 1'b0;
            end
            load_valid = 1'b1;
            load_data  = 32'hBBBB0000 + 32'(i);
            sb.push_back(load_data);
            cyc();
        end
        load_valid = 1'b0;
        mem_write_enable = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_done: actual %b required 1", load_done); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reload_fault: actual %b required 0", fault); end
        for (int i = 0; i < 5; i++) begin
            pc = 8'(i * 4);
            #1;
            pop_exp(exp_w);
            n_checks++; if (instruction !== exp_w) begin n_fail++; $display("FAIL reload_pc%0d: actual %h required %h", i * 4, instruction, exp_w); end
        end
        pc = 8'd0;
        mem_addr = 32'h10;
        sb.push_back(32'hDEADBEEF);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL idle_write_ignored: actual %h required %h", mem_data, exp_w); end
    endtask

    task automatic test_misaligned();
        mem_addr = 32'h21;
        mem_write_enable = 1'b1;
        mem_write_data = 32'h5A5A1234;
        cyc();
        mem_write_enable = 1'b0;
        #1;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL misaligned_fault: actual %b required 1", fault); end
        sb.push_back(32'h005A5A12);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL misaligned_read_21: actual %h required %h", mem_data, exp_w); end
        mem_addr = 32'h20;
        sb.push_back(32'h5A5A1234);
        #1;
        pop_exp(exp_w);
        n_checks++; if (mem_data !== exp_w) begin n_fail++; $display("FAIL misaligned_read_20: actual %h required %h", mem_data, exp_w); end
    endtask

    initial begin
        rst = 1'b1;
        pc = 8'd0;
        mem_addr = 32'd0;
        mem_write_enable = 1'b0;
        mem_write_data = 32'd0;
        load_start = 1'b0;
        load_count = 8'd0;
        load_valid = 1'b0;
        load_data = 32'd0;
        test_reset();
        test_zero_load();
        test_load();
        test_dmem_rw();
        test_out_of_range();
        test_reset_mid_load();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
